// File: rtl/serial_parity_tx.sv
// Parity-framed serial transmitter: start bit, WIDTH data bits LSB-first, parity bit, stop bit.
// Define PARITY_ODD_EN for odd parity; the default build sends even parity.
module serial_parity_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [TW-1:0]    tick, tick_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shift, shift_n;
    logic             parity, parity_n;
    logic             tx_n, ready_n, busy_n, done_n;
    logic             bit_end;
    logic             word_parity;

`ifdef PARITY_ODD_EN
    assign word_parity = ~^data_in;
`else
    assign word_parity = ^data_in;
`endif

    // Compared with >= so an out-of-range count still ends the bit instead of running on.
    assign bit_end = (tick >= TICK_LAST);

    always_comb begin
        state_n   = state;
        tick_n    = tick;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        parity_n  = parity;

        if (state != IDLE) begin
            tick_n = bit_end ? '0 : tick + 1'b1;
        end

        case (state)
            IDLE: begin
                tick_n    = '0;
                bit_cnt_n = '0;
                if (load) begin
                    state_n  = START;
                    shift_n  = data_in;
                    parity_n = word_parity;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    if (bit_cnt >= BIT_LAST) begin
                        bit_cnt_n = '0;
                        state_n   = PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                if (bit_end) state_n = IDLE;
            end
            default: begin
                state_n   = IDLE;
                tick_n    = '0;
                bit_cnt_n = '0;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered without lag.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = parity_n;
            default: tx_n = 1'b1;
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == STOP) && (tick_n >= TICK_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            parity  <= 1'b0;
            tx_out  <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            parity  <= parity_n;
            tx_out  <= tx_n;
            ready   <= ready_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_serial_parity_tx.sv
// Bench for serial_parity_tx: one instance at 1 clock/bit, one at 4 clocks/bit, checked against a frame model.
module tb_serial_parity_tx;
`ifdef PARITY_ODD_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif
    localparam logic [10:0] PBIT = ODD ? 11'h200 : 11'h000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       load1 = 1'b0;
    logic       load4 = 1'b0;
    logic [7:0] data1 = '0;
    logic [7:0] data4 = '0;
    logic       ready1, tx1, busy1, done1;
    logic       ready4, tx4, busy4, done4;

    int checks = 0;
    int errors = 0;

    bit          m_busy  [2];
    int          m_pos   [2];
    logic [10:0] m_frame [2];

    always #5 clk = ~clk;

    serial_parity_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data1), .load(load1),
        .ready(ready1), .tx_out(tx1), .busy(busy1), .done(done1)
    );

    serial_parity_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_in(data4), .load(load4),
        .ready(ready4), .tx_out(tx4), .busy(busy4), .done(done4)
    );

    function automatic int cpb(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Whole frame as line bits in send order, bit 0 first on the wire.
    function automatic logic [10:0] make_frame(input logic [7:0] d);
        logic p;
        p = ((($countones(d) % 2) != 0) ? 1'b1 : 1'b0) ^ ODD;
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame model: clocks elapsed since the accept edge select the bit on the line.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 1'b0;
                m_pos[i]  = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_busy[i]) begin
                    m_pos[i]++;
                    if (m_pos[i] == 11 * cpb(i)) m_busy[i] = 1'b0;
                end else if ((i == 0) ? load1 : load4) begin
                    m_busy[i]  = 1'b1;
                    m_pos[i]   = 0;
                    m_frame[i] = make_frame((i == 0) ? data1 : data4);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic etx, edone;
            if (m_busy[i]) begin
                etx   = m_frame[i][m_pos[i] / cpb(i)];
                edone = (m_pos[i] == 11 * cpb(i) - 1);
            end else begin
                etx   = 1'b1;
                edone = 1'b0;
            end
            check_output($sformatf("tx_cpb%0d", cpb(i)), (i == 0) ? tx1 : tx4, etx);
            check_output($sformatf("done_cpb%0d", cpb(i)), (i == 0) ? done1 : done4, edone);
            check_output($sformatf("busy_cpb%0d", cpb(i)), (i == 0) ? busy1 : busy4, m_busy[i]);
            check_output($sformatf("ready_cpb%0d", cpb(i)), (i == 0) ? ready1 : ready4, !m_busy[i]);
        end
    end

    task automatic apply_stimulus(input logic [7:0] d, output logic [10:0] line,
                                  output logic [11:0] rdy, output logic [11:0] dn);
        @(negedge clk);
        load1 = 1'b1;
        data1 = d;
        @(negedge clk);
        load1 = 1'b0;
        data1 = ~d;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 11) line[k] = tx1;
            rdy[k] = ready1;
            dn[k]  = done1;
        end
    endtask

    initial begin
        logic [10:0] line;
        logic [11:0] rdy, dn;
        logic [43:0] line4, exp44;
        logic [10:0] exp11;
        logic [22:0] cont;
        logic [7:0]  rec;
        int          busy_cnt;

        #1 rst_n = 1'b0;
        load1 = 1'b1;
        load4 = 1'b1;
        data1 = 8'hA5;
        data4 = 8'h81;
        repeat (3) @(negedge clk);
        check_output("reset_tx", tx1, 1'b1);
        check_output("reset_ready", ready1, 1'b1);
        check_output("reset_busy", busy1, 1'b0);
        check_output("reset_done", done4, 1'b0);
        load1 = 1'b0;
        load4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("idle_after_reset", {tx1, busy1, tx4, busy4}, 4'b1010);

        apply_stimulus(8'hA5, line, rdy, dn);
        $display("[TB] frame A5 line=%b", line);
        check_output("a5_line", line, 11'b1_0_10100101_0 ^ PBIT);
        check_output("a5_done_pos", dn, 12'h400);
        check_output("a5_ready_pos", rdy, 12'h800);

        apply_stimulus(8'h07, line, rdy, dn);
        check_output("parity_07", line[9], 1'b1 ^ ODD);
        apply_stimulus(8'h00, line, rdy, dn);
        check_output("parity_00", line[9], 1'b0 ^ ODD);

        @(negedge clk);
        load4 = 1'b1;
        data4 = 8'h81;
        @(negedge clk);
        load4 = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 44; k++) begin
            if (k > 0) @(negedge clk);
            line4[k] = tx4;
            if (busy4) busy_cnt++;
            if (k == 20) begin
                load4 = 1'b1;
                data4 = 8'hFF;
            end
            if (k == 21) load4 = 1'b0;
        end
        @(negedge clk);
        check_output("frame4_end_ready", ready4, 1'b1);
        check_output("frame4_len", busy_cnt, 44);
        exp11 = 11'b1_0_10000001_0 ^ PBIT;
        for (int k = 0; k < 44; k++) exp44[k] = exp11[k / 4];
        check_output("frame4_line_lo", line4[31:0], exp44[31:0]);
        check_output("frame4_line_hi", line4[43:32], exp44[43:32]);
        for (int b = 0; b < 8; b++) rec[b] = line4[4 * (b + 1) + 2];
        check_output("frame4_data", rec, 8'h81);

        @(negedge clk);
        load1 = 1'b1;
        data1 = 8'h3C;
        @(negedge clk);
        data1 = 8'hC3;
        for (int k = 0; k < 23; k++) begin
            if (k > 0) @(negedge clk);
            cont[k] = tx1;
            if (k == 12) data1 = 8'h3C;
            if (k == 22) load1 = 1'b0;
        end
        check_output("b2b_gap_idle", cont[11], 1'b1);
        check_output("b2b_second_start", cont[12], 1'b0);
        check_output("b2b_line", cont,
                     {11'b1_0_11000011_0 ^ PBIT, 1'b1, 11'b1_0_00111100_0 ^ PBIT});

        repeat (2) @(negedge clk);
        load1 = 1'b1;
        data1 = 8'hF0;
        @(negedge clk);
        load1 = 1'b0;
        repeat (3) @(negedge clk);
        check_output("pre_reset_data_bit", tx1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_reset_tx", tx1, 1'b1);
        check_output("async_reset_busy", busy1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_output("no_done_in_reset", done1, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(8'h0F, line, rdy, dn);
        check_output("after_reset_line", line, 11'b1_0_00001111_0 ^ PBIT);
        check_output("after_reset_done_pos", dn, 12'h400);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
